axi_burst_master: RTL and testbench

AXI4 master bridge that turns single-request cache/LSU transfers into AXI4 INCR bursts on a 64-bit data bus. It sits between the core's memory-side clients (icache refill, dcache refill/writeback, uncached LSU) and the AXI slave (simulation SRAM in the NPC testbench). It handles one transaction at a time, read or write: it streams read beats back to the client and writes beats supplied by the client.

---
 rtl/axi_burst_master_if.sv | 69 ++++++
 rtl/axi_burst_master.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_if.sv
// AXI4 channel bundle (AR/R/AW/W/B) between axi_burst_master and its slave.
interface axi_burst_master_if;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: turns one client request into one
// AR/R or AW/W/B exchange, streaming read beats out and write beats in.
module axi_burst_master (
    input  logic               aclk,
    input  logic               areset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wen,
    input  logic [31:0]        req_addr,
    input  logic [7:0]         req_len,
    input  logic [2:0]         req_size,
    input  logic [63:0]        wbeat_data,
    input  logic [7:0]         wbeat_strb,
    input  logic               wbeat_valid,
    output logic               wbeat_ready,
    output logic [63:0]        rbeat_data,
    output logic               rbeat_valid,
    output logic               rbeat_last,
    output logic               resp_done,
    output logic               resp_err,
    axi_burst_master_if.master axi
);

    localparam logic [3:0] RD_ID = 4'h0;
    localparam logic [3:0] WR_ID = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_WRESP = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [63:0] rbeat_data_q, rbeat_data_d;
    logic        rbeat_valid_q, rbeat_valid_d;
    logic        rbeat_last_q, rbeat_last_d;
    logic        resp_done_q, resp_done_d;
    logic        resp_err_q, resp_err_d;

    logic        in_write_s;
    logic        w_open_s;
    logic        r_hs_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        b_hs_s;
    logic        w_last_s;
    logic        r_len_err_s;
    logic        r_err_s;
    logic        unused_ids_s;

    assign in_write_s = (state_q == ST_WRITE);
    assign w_open_s   = in_write_s & ~w_done_q;
    assign w_last_s   = (cnt_q == len_q);

    assign r_hs_s  = (state_q == ST_RDATA) & axi.rvalid;
    assign aw_hs_s = in_write_s & ~aw_done_q & axi.awready;
    assign w_hs_s  = w_open_s & wbeat_valid & axi.wready;
    assign b_hs_s  = (state_q == ST_WRESP) & axi.bvalid;

    // A beat with rlast must land on beat len; a beat at len without rlast overruns.
    assign r_len_err_s = axi.rlast ? (cnt_q != len_q) : (cnt_q == len_q);
    assign r_err_s     = err_q | (axi.rresp != 2'b00) | r_len_err_s;

    assign unused_ids_s = ^{axi.rid, axi.bid};

    assign req_ready   = (state_q == ST_IDLE);
    assign wbeat_ready = w_open_s & axi.wready;
    assign rbeat_data  = rbeat_data_q;
    assign rbeat_valid = rbeat_valid_q;
    assign rbeat_last  = rbeat_last_q;
    assign resp_done   = resp_done_q;
    assign resp_err    = resp_err_q;

    assign axi.araddr  = addr_q;
    assign axi.arid    = RD_ID;
    assign axi.arlen   = len_q;
    assign axi.arsize  = size_q;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = (state_q == ST_RADDR);
    assign axi.rready  = (state_q == ST_RDATA);

    assign axi.awaddr  = addr_q;
    assign axi.awid    = WR_ID;
    assign axi.awlen   = len_q;
    assign axi.awsize  = size_q;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = in_write_s & ~aw_done_q;

    assign axi.wid     = WR_ID;
    assign axi.wdata   = wbeat_data;
    assign axi.wstrb   = wbeat_strb;
    assign axi.wlast   = w_last_s;
    assign axi.wvalid  = w_open_s & wbeat_valid;
    assign axi.bready  = (state_q == ST_WRESP);

    // Next-state, latched request fields and the registered client-side pulses.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rbeat_data_d  = rbeat_data_q;
        rbeat_valid_d = 1'b0;
        rbeat_last_d  = 1'b0;
        resp_done_d   = 1'b0;
        resp_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    len_d     = req_len;
                    size_d    = req_size;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? ST_WRITE : ST_RADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (axi.arready) begin
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (r_hs_s) begin
                    rbeat_data_d  = axi.rdata;
                    rbeat_valid_d = 1'b1;
                    cnt_d         = cnt_q + 8'd1;
                    err_d         = r_err_s;
                    if (axi.rlast) begin
                        rbeat_last_d = 1'b1;
                        resp_done_d  = 1'b1;
                        resp_err_d   = r_err_s;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_WRITE: begin
                if (aw_hs_s) begin
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (w_hs_s) begin
                    cnt_d    = cnt_q + 8'd1;
                    w_done_d = w_last_s;
                end else begin
                    w_done_d = w_done_q;
                end
                // Both flags may complete on the same edge; look at the next values.
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRESP: begin
                if (b_hs_s) begin
                    err_d       = err_q | (axi.bresp != 2'b00);
                    resp_done_d = 1'b1;
                    resp_err_d  = err_q | (axi.bresp != 2'b00);
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WRESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            addr_q        <= 32'h0000_0000;
            len_q         <= 8'd0;
            size_q        <= 3'd0;
            cnt_q         <= 8'd0;
            err_q         <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rbeat_data_q  <= 64'h0;
            rbeat_valid_q <= 1'b0;
            rbeat_last_q  <= 1'b0;
            resp_done_q   <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            size_q        <= size_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            rbeat_data_q  <= rbeat_data_d;
            rbeat_valid_q <= rbeat_valid_d;
            rbeat_last_q  <= rbeat_last_d;
            resp_done_q   <= resp_done_d;
            resp_err_q    <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: the bench plays AXI slave and client, and checks
// every bus/client observation against transaction-level expectations.
module tb_axi_burst_master;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [63:0] wbeat_data;
    logic [7:0]  wbeat_strb;
    logic        wbeat_valid;
    logic        wbeat_ready;
    logic [63:0] rbeat_data;
    logic        rbeat_valid;
    logic        rbeat_last;
    logic        resp_done;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    axi_burst_master_if axi_if();

    axi_burst_master dut (
        .aclk        (aclk),
        .areset      (areset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_size    (req_size),
        .wbeat_data  (wbeat_data),
        .wbeat_strb  (wbeat_strb),
        .wbeat_valid (wbeat_valid),
        .wbeat_ready (wbeat_ready),
        .rbeat_data  (rbeat_data),
        .rbeat_valid (rbeat_valid),
        .rbeat_last  (rbeat_last),
        .resp_done   (resp_done),
        .resp_err    (resp_err),
        .axi         (axi_if)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        req_valid       = 1'b0;
        req_wen         = 1'b0;
        req_addr        = 32'h0;
        req_len         = 8'd0;
        req_size        = 3'd0;
        wbeat_data      = 64'h0;
        wbeat_strb      = 8'h0;
        wbeat_valid     = 1'b0;
        axi_if.arready  = 1'b0;
        axi_if.rid      = 4'h0;
        axi_if.rdata    = 64'h0;
        axi_if.rresp    = 2'b00;
        axi_if.rlast    = 1'b0;
        axi_if.rvalid   = 1'b0;
        axi_if.awready  = 1'b0;
        axi_if.wready   = 1'b0;
        axi_if.bid      = 4'h1;
        axi_if.bresp    = 2'b00;
        axi_if.bvalid   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_arvalid"}, 64'(axi_if.arvalid), 64'd0);
        check({tag, "_rready"}, 64'(axi_if.rready), 64'd0);
        check({tag, "_awvalid"}, 64'(axi_if.awvalid), 64'd0);
        check({tag, "_bready"}, 64'(axi_if.bready), 64'd0);
        check({tag, "_rbeat_valid"}, 64'(rbeat_valid), 64'd0);
        check({tag, "_resp_done"}, 64'(resp_done), 64'd0);
    endtask

    task automatic issue_req(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size);
        check("req_ready_before", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_len   = len;
        req_size  = size;
        @(negedge aclk);
        req_valid = 1'b0;
        check("req_ready_busy", 64'(req_ready), 64'd0);
    endtask

    // last_at: beat index on which the slave raises rlast; bad_beat: beat carrying bad_resp.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int bad_beat, input logic [1:0] bad_resp, input int last_at,
                           input bit pattern);
        logic [63:0] d;
        logic [7:0]  b;
        bit          exp_err;
        int          gap;
        exp_err = (last_at != int'(len));
        if (bad_beat >= 0 && bad_beat <= last_at && bad_resp != 2'b00) exp_err = 1'b1;
        issue_req(1'b0, addr, len, size);
        check("arvalid", 64'(axi_if.arvalid), 64'd1);
        check("araddr", 64'(axi_if.araddr), 64'(addr));
        check("arlen", 64'(axi_if.arlen), 64'(len));
        check("arsize", 64'(axi_if.arsize), 64'(size));
        check("arburst", 64'(axi_if.arburst), 64'd1);
        check("arid", 64'(axi_if.arid), 64'd0);
        check("ar_lcp", 64'({axi_if.arlock, axi_if.arcache, axi_if.arprot}), 64'd0);
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            @(negedge aclk);
            check("arvalid_hold", 64'(axi_if.arvalid), 64'd1);
            check("araddr_hold", 64'(axi_if.araddr), 64'(addr));
        end
        axi_if.arready = 1'b1;
        @(negedge aclk);
        axi_if.arready = 1'b0;
        check("arvalid_after_hs", 64'(axi_if.arvalid), 64'd0);
        for (int i = 0; i <= last_at; i++) begin
            check("rready", 64'(axi_if.rready), 64'd1);
            b = 8'h11 * 8'(i + 1);
            d = pattern ? {8{b}} : {$urandom, $urandom};
            axi_if.rvalid = 1'b1;
            axi_if.rdata  = d;
            axi_if.rlast  = (i == last_at);
            axi_if.rresp  = (i == bad_beat) ? bad_resp : 2'b00;
            @(negedge aclk);
            axi_if.rvalid = 1'b0;
            axi_if.rlast  = 1'b0;
            axi_if.rresp  = 2'b00;
            check("rbeat_valid", 64'(rbeat_valid), 64'd1);
            check("rbeat_data", rbeat_data, d);
            check("rbeat_last", 64'(rbeat_last), 64'(i == last_at));
            check("rd_resp_done", 64'(resp_done), 64'(i == last_at));
            if (i == last_at) begin
                check("rd_resp_err", 64'(resp_err), 64'(exp_err));
                check("rd_req_ready_end", 64'(req_ready), 64'd1);
                check("rd_rready_end", 64'(axi_if.rready), 64'd0);
            end else begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(negedge aclk);
                    check("rbeat_valid_gap", 64'(rbeat_valid), 64'd0);
                    check("resp_done_gap", 64'(resp_done), 64'd0);
                end
            end
        end
        @(negedge aclk);
        check("rd_resp_done_pulse", 64'(resp_done), 64'd0);
        check("rd_rbeat_valid_pulse", 64'(rbeat_valid), 64'd0);
    endtask

    // strb_sel < 0 picks random strobes; wv_pct/wr_pct set wbeat_valid/wready duty.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int aw_delay, input int wv_pct, input int wr_pct,
                            input int strb_sel, input logic [1:0] bresp,
                            output int aw_cyc, output int wl_cyc);
        logic [63:0] wd[$];
        logic [7:0]  ws[$];
        bit          aw_m;
        bit          w_m;
        int          wcnt;
        int          cyc;
        int          gap;
        aw_cyc = -1;
        wl_cyc = -1;
        for (int k = 0; k <= int'(len); k++) begin
            wd.push_back({$urandom, $urandom});
            ws.push_back((strb_sel < 0) ? 8'($urandom) : 8'(strb_sel));
        end
        issue_req(1'b1, addr, len, size);
        aw_m = 1'b0;
        w_m  = 1'b0;
        wcnt = 0;
        cyc  = 0;
        while (!(aw_m && w_m) && cyc < 400) begin
            axi_if.awready = (cyc >= aw_delay);
            wbeat_valid    = ($urandom_range(0, 99) < wv_pct);
            axi_if.wready  = ($urandom_range(0, 99) < wr_pct);
            wbeat_data     = w_m ? 64'h0 : wd[wcnt];
            wbeat_strb     = w_m ? 8'h0 : ws[wcnt];
            #1;
            check("awvalid", 64'(axi_if.awvalid), 64'(!aw_m));
            if (!aw_m) begin
                check("awaddr", 64'(axi_if.awaddr), 64'(addr));
                check("awlen", 64'(axi_if.awlen), 64'(len));
                check("awsize", 64'(axi_if.awsize), 64'(size));
                check("awid", 64'(axi_if.awid), 64'd1);
                check("awburst", 64'(axi_if.awburst), 64'd1);
                check("aw_lcp", 64'({axi_if.awlock, axi_if.awcache, axi_if.awprot}), 64'd0);
            end
            check("wvalid", 64'(axi_if.wvalid), 64'(!w_m && wbeat_valid));
            check("wbeat_ready", 64'(wbeat_ready), 64'(!w_m && axi_if.wready));
            if (!w_m && wbeat_valid) begin
                check("wdata", axi_if.wdata, wd[wcnt]);
                check("wstrb", 64'(axi_if.wstrb), 64'(ws[wcnt]));
                check("wlast", 64'(axi_if.wlast), 64'(wcnt == int'(len)));
                check("wid", 64'(axi_if.wid), 64'd1);
            end
            check("wr_bready_early", 64'(axi_if.bready), 64'd0);
            if (!aw_m && axi_if.awready) begin
                aw_m   = 1'b1;
                aw_cyc = cyc;
            end
            if (!w_m && wbeat_valid && axi_if.wready) begin
                if (wcnt == int'(len)) begin
                    w_m    = 1'b1;
                    wl_cyc = cyc;
                end else begin
                    wcnt++;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        check("write_phase_done", 64'(aw_m && w_m), 64'd1);
        axi_if.awready = 1'b0;
        axi_if.wready  = 1'b0;
        wbeat_valid    = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            check("bready_wait", 64'(axi_if.bready), 64'd1);
            check("wr_resp_done_early", 64'(resp_done), 64'd0);
            @(negedge aclk);
        end
        check("bready", 64'(axi_if.bready), 64'd1);
        axi_if.bvalid = 1'b1;
        axi_if.bresp  = bresp;
        @(negedge aclk);
        axi_if.bvalid = 1'b0;
        axi_if.bresp  = 2'b00;
        check("wr_resp_done", 64'(resp_done), 64'd1);
        check("wr_resp_err", 64'(resp_err), 64'(bresp != 2'b00));
        check("wr_req_ready_end", 64'(req_ready), 64'd1);
        check("wr_bready_end", 64'(axi_if.bready), 64'd0);
        @(negedge aclk);
        check("wr_resp_done_pulse", 64'(resp_done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int aw_c;
        int wl_c;
        int len_i;
        int last_at;
        int bad;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [1:0]  rsp;

        quiet_inputs();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check_quiet("in_reset");
        check("in_reset_rbeat_data", rbeat_data, 64'h0);
        check("in_reset_resp_err", 64'(resp_err), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check_quiet("after_reset");

        // Directed read burst with recognisable beat data.
        do_read(32'h8000_0000, 8'd3, 3'd3, -1, 2'b00, 3, 1'b1);
        // Single-beat write, AW and W accepted together.
        do_write(32'h8000_0100, 8'd0, 3'd3, 0, 100, 100, 8'h0F, 2'b00, aw_c, wl_c);
        check("single_aw_cycle", 64'(aw_c), 64'd0);
        check("single_w_cycle", 64'(wl_c), 64'd0);
        // Two-beat write whose W beats finish before AW.
        do_write(32'h8000_0200, 8'd1, 3'd3, 5, 100, 100, -1, 2'b00, aw_c, wl_c);
        check("w_before_aw", 64'(wl_c < aw_c), 64'd1);
        check("aw_delay_cycle", 64'(aw_c), 64'd5);
        // Error responses.
        do_read(32'h8000_0300, 8'd1, 3'd3, 1, 2'b10, 1, 1'b0);
        do_write(32'h8000_0400, 8'd2, 3'd2, 1, 80, 80, -1, 2'b11, aw_c, wl_c);
        // Early rlast and late rlast.
        do_read(32'h8000_0500, 8'd3, 3'd3, -1, 2'b00, 1, 1'b0);
        @(negedge aclk);
        check_quiet("after_early_rlast");
        do_read(32'h8000_0600, 8'd1, 3'd3, -1, 2'b00, 2, 1'b0);
        // Longest burst: 256 beats, counter must not flag a wrap.
        do_read(32'h8000_1000, 8'd255, 3'd3, -1, 2'b00, 255, 1'b0);

        // Reset while the third beat of a read is on the bus.
        issue_req(1'b0, 32'h8000_0700, 8'd3, 3'd3);
        axi_if.arready = 1'b1;
        @(negedge aclk);
        axi_if.arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi_if.rvalid = 1'b1;
            axi_if.rdata  = {$urandom, $urandom};
            @(negedge aclk);
        end
        areset = 1'b1;
        @(negedge aclk);
        areset        = 1'b0;
        axi_if.rvalid = 1'b0;
        check_quiet("mid_reset");
        @(negedge aclk);
        check_quiet("mid_reset_next");

        // Randomised mix of reads and writes.
        for (int t = 0; t < 30; t++) begin
            len_i = $urandom_range(0, 12);
            sz    = 3'($urandom_range(0, 3));
            ad    = 32'h8000_0000 | ($urandom & 32'h0000_FFF8);
            if ($urandom_range(0, 1) == 0) begin
                bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len_i) : -1;
                rsp = 2'($urandom_range(1, 3));
                last_at = len_i;
                if ($urandom_range(0, 5) == 0) begin
                    last_at = (len_i > 0) ? $urandom_range(0, len_i - 1) : 1;
                end
                do_read(ad, 8'(len_i), sz, bad, rsp, last_at, 1'b0);
            end else begin
                rsp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                do_write(ad, 8'(len_i), sz, $urandom_range(0, 6), $urandom_range(40, 100),
                         $urandom_range(40, 100), -1, rsp, aw_c, wl_c);
            end
            repeat ($urandom_range(0, 2)) @(negedge aclk);
        end

        @(negedge aclk);
        check_quiet("final_idle");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
